// File: rtl/uart_receiver_pkg.sv
// Shared UART receive definitions: FSM state encoding and legal oversampling ratios.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, per-bit oversampling counter and 3-sample majority vote.
module uart_rx_sampler (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_data_in,
  input  logic [5:0] prescale,
  input  logic       cnt_clear,
  output logic       rx_s,
  output logic       bit_end,
  output logic       sample_ready,
  output logic       sampled_bit
);

  logic       sync_1;
  logic       sync_2;
  logic [5:0] edge_cnt;
  logic [2:0] samp;
  logic [5:0] half;
  logic [5:0] last;

  assign half = {1'b0, prescale[5:1]};
  assign last = prescale - 6'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= serial_data_in;
      sync_2 <= sync_1;
    end
  end

  assign rx_s = sync_2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cnt <= '0;
    end else if (cnt_clear || edge_cnt == last) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  // Samples persist until the next bit's first sample point, so the vote
  // stays valid through the end of the bit period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp <= '0;
    end else begin
      if (edge_cnt == half - 6'd1) samp[0] <= rx_s;
      if (edge_cnt == half)        samp[1] <= rx_s;
      if (edge_cnt == half + 6'd1) samp[2] <= rx_s;
    end
  end

  assign bit_end      = (edge_cnt == last);
  assign sample_ready = (edge_cnt == half + 6'd2);
  assign sampled_bit  = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: frame FSM, LSB-first deserialiser and parity/stop checking.
module uart_receiver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_data_in,
  input  logic [5:0]            prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  output logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  busy
);
  import uart_receiver_pkg::*;

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  rx_state_t             state;
  rx_state_t             state_next;
  logic [5:0]            p_lat;
  logic                  pe_lat;
  logic                  pt_lat;
  logic                  par_err;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  rx_s;
  logic                  bit_end;
  logic                  sample_ready;
  logic                  sampled_bit;
  logic                  glitch;
  logic                  cnt_clear;

  uart_rx_sampler u_sampler (
    .clk            (clk),
    .reset          (reset),
    .serial_data_in (serial_data_in),
    .prescale       (p_lat),
    .cnt_clear      (cnt_clear),
    .rx_s           (rx_s),
    .bit_end        (bit_end),
    .sample_ready   (sample_ready),
    .sampled_bit    (sampled_bit)
  );

  assign glitch    = (state == START) && sample_ready && sampled_bit;
  assign cnt_clear = (state == IDLE) || glitch;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (!rx_s) state_next = START;
      START: begin
        if (glitch)       state_next = IDLE;
        else if (bit_end) state_next = DATA;
      end
      DATA:   if (bit_end && bit_cnt == LAST_BIT) state_next = pe_lat ? PARITY : STOP;
      PARITY: if (bit_end) state_next = STOP;
      STOP:   if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_lat         <= '0;
      pe_lat        <= 1'b0;
      pt_lat        <= 1'b0;
      par_err       <= 1'b0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      parallel_data <= '0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      stop_error    <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            p_lat   <= prescale;
            pe_lat  <= parity_enable;
            pt_lat  <= parity_type;
            par_err <= 1'b0;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (sample_ready) shift_reg <= {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          if (bit_end)      bit_cnt   <= bit_cnt + BCW'(1);
        end
        PARITY: begin
          if (sample_ready)
            par_err <= (sampled_bit != (pt_lat ? ~^shift_reg : ^shift_reg));
        end
        STOP: begin
          if (bit_end) begin
            if (!sampled_bit) begin
              stop_error <= 1'b1;
            end else if (par_err) begin
              parity_error <= 1'b1;
            end else begin
              data_valid    <= 1'b1;
              parallel_data <= shift_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are queued as driven and checked as pulses appear.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_data_in;
  logic [5:0] prescale;
  logic       parity_enable;
  logic       parity_type;
  logic [7:0] parallel_data;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;
  logic       busy;

  uart_receiver #(.DATA_WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_data_in (serial_data_in),
    .prescale       (prescale),
    .parity_enable  (parity_enable),
    .parity_type    (parity_type),
    .parallel_data  (parallel_data),
    .data_valid     (data_valid),
    .parity_error   (parity_error),
    .stop_error     (stop_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_PAR   = 3'b010;
  localparam logic [2:0] K_STOP  = 3'b100;

  typedef struct {
    logic [2:0]  kind;
    logic [7:0]  data;
    int unsigned fall;
    int unsigned lat;
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  last_good = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (data_valid || parity_error || stop_error)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({stop_error, parity_error, data_valid}), 32'(3'b000));
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'({stop_error, parity_error, data_valid}), 32'(e.kind));
        check("word", 32'(parallel_data), 32'((e.kind == K_VALID) ? e.data : last_good));
        if (e.chk_lat) check("latency", cyc - e.fall, e.lat);
        if (e.kind == K_VALID) last_good = e.data;
      end
    end
  end

  task automatic idle(input int n);
    serial_data_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // abort_bit >= 0 stops halfway through that frame bit and queues nothing.
  task automatic send_frame(input logic [7:0] data, input logic [5:0] p, input logic pe,
                            input logic pt, input logic bad_par, input logic stop_val,
                            input bit chk_lat, input int abort_bit);
    logic [11:0] bits;
    logic        par;
    int          nb;
    exp_t        e;
    par  = pt ? ~^data : ^data;
    nb   = pe ? 11 : 10;
    bits = '1;
    bits[0]   = 1'b0;
    bits[8:1] = data;
    if (pe) begin
      bits[9]  = par ^ bad_par;
      bits[10] = stop_val;
    end else begin
      bits[9] = stop_val;
    end
    prescale      = p;
    parity_enable = pe;
    parity_type   = pt;
    if (abort_bit < 0) begin
      e.kind    = !stop_val ? K_STOP : ((pe && bad_par) ? K_PAR : K_VALID);
      e.data    = data;
      e.fall    = cyc;
      e.lat     = 3 + nb * int'(p);
      e.chk_lat = chk_lat;
      sb.push_back(e);
    end
    for (int i = 0; i < nb; i++) begin
      serial_data_in = bits[i];
      if (i == abort_bit) begin
        repeat (p / 2) @(posedge clk);
        #1;
        return;
      end
      if (i == 0) begin
        repeat (5) @(posedge clk);
        #1;
        prescale      = (p == PRESCALE_8) ? PRESCALE_16 : PRESCALE_8;
        parity_enable = ~pe;
        parity_type   = ~pt;
        repeat (p - 6'd5) @(posedge clk);
        #1;
      end else begin
        repeat (p) @(posedge clk);
        #1;
      end
    end
    serial_data_in = 1'b1;
  endtask

  initial begin
    reset          = 1'b1;
    serial_data_in = 1'b1;
    prescale       = PRESCALE_8;
    parity_enable  = 1'b0;
    parity_type    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({parallel_data, data_valid, parity_error, stop_error, busy}), 32'(0));
    reset = 1'b0;
    idle(4);

    send_frame(8'hE6, PRESCALE_8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    idle(20);
    send_frame(8'hFF, PRESCALE_16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    idle(20);
    send_frame(8'hF4, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    send_frame(8'h3C, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(20);
    send_frame(8'hA5, PRESCALE_8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    idle(20);
    send_frame(8'h5A, PRESCALE_8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(20);

    prescale       = PRESCALE_16;
    serial_data_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    serial_data_in = 1'b1;
    check("glitch_busy_high", 32'(busy), 32'(1));
    repeat (11) @(posedge clk);
    #1;
    check("glitch_busy_low", 32'(busy), 32'(0));
    idle(20);

    send_frame(8'h3C, PRESCALE_8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    check("mid_frame_busy", 32'(busy), 32'(1));
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'({parallel_data, data_valid, parity_error, stop_error, busy}), 32'(0));
    last_good = 8'h00;
    serial_data_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(10);
    send_frame(8'h81, PRESCALE_8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, -1);
    idle(10);

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drain", 32'(sb.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
